// File: rtl/fifo_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : fifo_traffic_gen
// Description : Stimulus source for a synchronous FIFO. It runs three phases:
//               FILL (writes past full), DRAIN (reads past empty) and RANDOM
//               (LFSR-driven mixed traffic). It reports phase, progress and
//               per-run write/read cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_traffic_gen #(
  parameter int          FIFO_WIDTH  = 16,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          RAND_CYCLES = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [7:0]  WR_THRESH   = 8'd179,
  parameter logic [7:0]  RD_THRESH   = 8'd77
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  full,
  input  logic                  empty,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [2:0]            phase,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           wr_cnt,
  output logic [15:0]           rd_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_DRAIN  = 3'd2,
    S_RANDOM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Last phase-counter value of each timed phase.
  localparam logic [15:0] FILL_LAST = 16'(FIFO_DEPTH + 1);
  localparam logic [15:0] RAND_LAST = 16'(RAND_CYCLES - 1);

  // The FIFO flags are observed by the environment, not by this generator.
  logic unused_flags;
  assign unused_flags = full ^ empty;

  // The control state runs one cycle ahead of the registered outputs: the
  // state register decides what the output stage presents on the next edge.
  state_t          state, state_nxt;
  logic [15:0]     cnt, cnt_nxt;
  logic [15:0]     lfsr, lfsr_nxt;
  logic            lfsr_fb;
  logic [2:0]      phase_nxt;
  logic [FIFO_WIDTH-1:0] data_nxt;
  logic            wr_nxt, rd_nxt;
  logic            clr_cnts;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Control state, phase counter and LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      lfsr  <= LFSR_SEED;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lfsr  <= lfsr_nxt;
    end
  end

  // Next control state and next output values; hold freezes everything in
  // the timed phases while start is still accepted when not busy.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lfsr_nxt  = lfsr;
    phase_nxt = phase;
    data_nxt  = data_in;
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    clr_cnts  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (!hold) begin
          phase_nxt = state;
        end
        // busy still reflects the tail of RANDOM on the first DONE cycle.
        if (start && !busy) begin
          state_nxt = S_FILL;
          cnt_nxt   = '0;
          clr_cnts  = 1'b1;
        end
      end
      S_FILL: begin
        if (!hold) begin
          phase_nxt = S_FILL;
          wr_nxt    = 1'b1;
          data_nxt  = cnt[FIFO_WIDTH-1:0];
          if (cnt == FILL_LAST) begin
            state_nxt = S_DRAIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!hold) begin
          phase_nxt = S_DRAIN;
          rd_nxt    = 1'b1;
          if (cnt == FILL_LAST) begin
            state_nxt = S_RANDOM;
            cnt_nxt   = '0;
            lfsr_nxt  = LFSR_SEED;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      S_RANDOM: begin
        if (!hold) begin
          phase_nxt = S_RANDOM;
          data_nxt  = lfsr[FIFO_WIDTH-1:0];
          wr_nxt    = (lfsr[7:0] < WR_THRESH);
          rd_nxt    = (lfsr[15:8] < RD_THRESH);
          lfsr_nxt  = {lfsr[14:0], lfsr_fb};
          if (cnt == RAND_LAST) begin
            state_nxt = S_DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs and saturating per-run enable counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 3'd0;
      data_in <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      phase   <= phase_nxt;
      data_in <= data_nxt;
      wr_en   <= wr_nxt;
      rd_en   <= rd_nxt;
      busy    <= (phase_nxt == S_FILL) || (phase_nxt == S_DRAIN) ||
                 (phase_nxt == S_RANDOM);
      done    <= (phase_nxt == S_DONE);
      if (clr_cnts) begin
        wr_cnt <= '0;
      end else if (wr_nxt && (wr_cnt != 16'hFFFF)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (clr_cnts) begin
        rd_cnt <= '0;
      end else if (rd_nxt && (rd_cnt != 16'hFFFF)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_traffic_gen
// Description : Scoreboard bench for fifo_traffic_gen. Directed runs push the
//               expected enable transactions; a negedge monitor pops and
//               compares each cycle the generator asserts wr_en or rd_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_traffic_gen;

  localparam int          W    = 16;
  localparam int          D    = 8;
  localparam int          R    = 256;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          hold  = 1'b0;
  logic          full  = 1'b0;
  logic          empty = 1'b1;
  logic [W-1:0]  data_in;
  logic          wr_en, rd_en, busy, done;
  logic [2:0]    phase;
  logic [15:0]   wr_cnt, rd_cnt;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [15:0] data;
    logic [2:0]  ph;
  } item_t;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_wr = 0;
  int    exp_rd = 0;

  fifo_traffic_gen #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D),
    .RAND_CYCLES(R),
    .LFSR_SEED  (SEED),
    .WR_THRESH  (8'd179),
    .RD_THRESH  (8'd77)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .hold   (hold),
    .full   (full),
    .empty  (empty),
    .data_in(data_in),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .phase  (phase),
    .busy   (busy),
    .done   (done),
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected transactions of one complete run, plus per-run enable totals.
  task automatic push_run();
    item_t       it;
    logic [15:0] l;
    logic        w, r;
    exp_wr = D + 2;
    exp_rd = D + 2;
    for (int i = 0; i < D + 2; i++) begin
      it.wr = 1'b1; it.rd = 1'b0; it.data = 16'(i); it.ph = 3'd1;
      sbq.push_back(it);
    end
    for (int i = 0; i < D + 2; i++) begin
      it.wr = 1'b0; it.rd = 1'b1; it.data = 16'(D + 1); it.ph = 3'd2;
      sbq.push_back(it);
    end
    l = SEED;
    for (int i = 0; i < R; i++) begin
      w = (l[7:0] < 8'd179);
      r = (l[15:8] < 8'd77);
      if (w || r) begin
        it.wr = w; it.rd = r; it.data = l; it.ph = 3'd3;
        sbq.push_back(it);
      end
      exp_wr += int'(w);
      exp_rd += int'(r);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  // Scoreboard monitor: every enabled cycle must match the next expected item.
  always @(negedge clk) begin
    item_t got, e;
    if (rst_n && (wr_en || rd_en)) begin
      checks++;
      got.wr = wr_en; got.rd = rd_en; got.data = data_in; got.ph = phase;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got wr=%b rd=%b data=%h phase=%0d expected no enable",
                 wr_en, rd_en, data_in, phase);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_item: got wr=%b rd=%b data=%h phase=%0d expected wr=%b rd=%b data=%h phase=%0d",
                   got.wr, got.rd, got.data, got.ph, e.wr, e.rd, e.data, e.ph);
        end
      end
    end
  end

  // One run from a start pulse to done, with optional hold and start poke.
  task automatic do_run(input bit use_hold, input bit poke_drain, input int exp_cycles);
    int          cyc;
    bit          held;
    logic [2:0]  prev;
    logic [11:0] seq;
    logic [7:0]  nseq;
    logic [15:0] wc, rc;
    push_run();
    prev = phase;
    seq  = '0;
    nseq = '0;
    held = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      tick();
      cyc++;
      if (phase != prev) begin
        seq  = {seq[8:0], phase};
        nseq = nseq + 8'd1;
        prev = phase;
      end
      if (cyc == 1)
        check("first_fill", 64'({phase, wr_en, rd_en, data_in, wr_cnt, rd_cnt}),
              64'({3'd1, 1'b1, 1'b0, 16'd0, 16'd1, 16'd0}));
      if (!use_hold) begin
        if (cyc == 10)
          check("fill_exit", 64'({phase, data_in, wr_cnt}), 64'({3'd1, 16'd9, 16'd10}));
        if (cyc == 20)
          check("drain_exit", 64'({phase, rd_en, rd_cnt, wr_cnt}),
                64'({3'd2, 1'b1, 16'd10, 16'd10}));
        if (cyc == 21)
          check("rand_first", 64'({phase, wr_en, rd_en, data_in}),
                64'({3'd3, 1'b0, 1'b0, 16'hACE1}));
        if (cyc == 22)
          check("rand_second", 64'({phase, wr_en, rd_en, data_in}),
                64'({3'd3, 1'b0, 1'b0, 16'h59C3}));
      end
      if (poke_drain) start = (cyc == 15);
      if (use_hold && !held && phase == 3'd1 && data_in == 16'd3) begin
        hold = 1'b1;
        repeat (5) begin
          tick();
          cyc++;
          check("hold_quiet", 64'({wr_en, rd_en, phase, data_in}),
                64'({1'b0, 1'b0, 3'd1, 16'd3}));
        end
        hold = 1'b0;
        held = 1'b1;
        tick();
        cyc++;
        check("hold_resume4", 64'({wr_en, data_in}), 64'({1'b1, 16'd4}));
        tick();
        cyc++;
        check("hold_resume5", 64'({wr_en, data_in}), 64'({1'b1, 16'd5}));
      end
      if (done) break;
    end
    start = 1'b0;
    check("done_time", 64'(cyc), 64'(exp_cycles));
    check("phase_seq", 64'({nseq, seq}), 64'({8'd4, 12'h29C}));
    check("run_counts", 64'({wr_cnt, rd_cnt}), 64'({16'(exp_wr), 16'(exp_rd)}));
    wc = wr_cnt;
    rc = rd_cnt;
    repeat (3) tick();
    check("done_hold", 64'({done, busy, wr_en, rd_en, phase, wr_cnt, rd_cnt}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 3'd4, wc, rc}));
    check("sb_drain", 64'(sbq.size()), 64'(0));
  endtask

  // Asynchronous reset in the middle of RANDOM.
  task automatic reset_mid_random();
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("pre_reset_phase", 64'(phase), 64'(3));
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    check("reset_mid_run", 64'({phase, wr_en, rd_en, busy, done, data_in, wr_cnt, rd_cnt}), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 64'({phase, busy, wr_en, rd_en, data_in}), 64'(0));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_async", 64'({phase, wr_en, rd_en, busy, done, data_in, wr_cnt, rd_cnt}), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_quiet", 64'({phase, busy, done, wr_en, rd_en}), 64'(0));

    do_run(1'b0, 1'b0, 277);   // basic run from IDLE
    do_run(1'b0, 1'b1, 277);   // restart from DONE, start poked during DRAIN
    do_run(1'b1, 1'b0, 282);   // 5-cycle hold in FILL
    reset_mid_random();
    do_run(1'b0, 1'b0, 277);   // replay after reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
